data_ram_dp: RTL and testbench
==============================

# data_ram_dp

Single-port synchronous data memory for the processor datapath: 1024 words × 32 bits, with a synchronous write port and a registered read port sharing one address bus. It serves as the data RAM behind the load/store unit. Writes are write-first, so a location written on an edge is visible on `salida` from that same edge.

## Interface
- `DATA_W`, default 32: word width in bits.
- `ADDR_W`, default 10: address width; depth is 2**ADDR_W words.

- `clock`, input, 1: single system clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `wren`, input, 1: write enable, sampled on the rising edge of `clock`.
- `address`, input, ADDR_W: word address shared by write and read.
- `data`, input, DATA_W: write data.
- `salida`, output, DATA_W: registered read data.

## Operation
- Storage is a DEPTH × DATA_W array with no byte enables.
- Data is treated as raw bits, so signed values are stored and returned unchanged.
- Write: on a rising edge with `reset_n`=1 and `wren`=1, `mem[address]` ← `data`.
- Read: on every rising edge with `reset_n`=1:
  - if `wren`=1, `salida` ← `data` (write-first bypass);
  - otherwise `salida` ← `mem[address]`.
- Every address 0..DEPTH-1 is valid. There is no wrap logic and no out-of-range case.
- Reset:
  - Asserting `reset_n`=0 clears `salida` (and the optional pipeline register) to 0 immediately, without waiting for a clock edge.
  - Memory contents are not cleared.
  - While reset is asserted, writes are suppressed, including an edge coincident with reset assertion.
- After power-up, memory contents are undefined (X in simulation) until written. The exception is the `RAM_DP_INIT_ZERO_EN`-independent case: none, so no initialization is performed.
- Consecutive writes to the same address on back-to-back edges: the last write wins, and `salida` tracks each written value edge by edge.

## Timing
- Write latency: data is stored on the rising edge where `wren`=1.
- Read latency: 1 cycle. `salida` reflects `address` as sampled at the previous rising edge.
- Read-during-write at the same address returns the new data on that edge.
- `salida` is purely registered, with no combinational path from any input.
- Reset-to-output: asynchronous. `salida` is 0 while `reset_n`=0 and for the first cycle after release, until the next rising edge loads it.
- Inputs must be stable around the rising edge. The bench drives inputs on the falling edge.

## Configuration
- `RAM_DP_OUT_REG_EN`: when defined, adds a second output register after the read register. Read and bypass latency become 2 cycles. The extra register is also async-cleared to 0 by `reset_n`.
- Without the macro: 1-cycle latency, exactly as described above.
- Write timing is identical in both builds.

## Test plan
- Reset: hold `reset_n`=0 with `wren`=1, `data`=32'hFFFFFFFF, `address`=5 for 3 edges, then release and read address 5 → `salida`=0 during reset, and address 5 does not hold 32'hFFFFFFFF.
- Write/read at address 1: drive `data`=43, `address`=1, `wren`=0 → 1; after 2 rising edges → `salida`=43.
- Write/read at address 32: `data`=61, `address`=32, same sequence → `salida`=61. Then, with `wren`=0 and `address`=1 → `salida`=43 one edge later, confirming no aliasing.
- Boundaries: write 32'h80000000 to address 0 and 32'h7FFFFFFF to address 1023, then read both back → exact values, sign bit preserved.
- Read-during-write: `wren`=1, `address`=7, `data`=10, then `data`=20 on the next edge → `salida`=10, then 20. With `wren`=0 → `salida` holds 20.
- Async reset mid-operation: after the writes above, pulse `reset_n` low between clock edges → `salida` goes to 0 before the next edge, and a subsequent read of address 32 returns 61.

Source files
------------

// File: rtl/data_ram_dp.sv
// Single-port 2**ADDR_W x DATA_W data RAM: synchronous write, registered write-first read.
// Define RAM_DP_OUT_REG_EN to add a second output register (2-cycle read latency).
module data_ram_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] salida
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // Storage has no reset; writes are gated by reset_n so an edge during reset never lands.
  always_ff @(posedge clock) begin
    if (reset_n && wren) begin
      mem_q[address] <= data;
    end
  end

  always_comb begin
    rd_d = wren ? data : mem_q[address];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef RAM_DP_OUT_REG_EN
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] out_q;

  always_comb begin
    out_d = rd_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign salida = out_q;
`else
  assign salida = rd_q;
`endif

endmodule

// File: tb/tb_data_ram_dp.sv
// Scoreboard bench for data_ram_dp: expected read data is queued per cycle and popped at the output.
module tb_data_ram_dp;

`ifdef RAM_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] val;
    bit          known;
    int          mode;
    string       name;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        wren;
  logic [9:0]  address;
  logic [31:0] data;
  logic [31:0] salida;

  logic [31:0] model_mem [1024];
  bit          model_known [1024];
  exp_t        sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  data_ram_dp #(.DATA_W(32), .ADDR_W(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wren    (wren),
    .address (address),
    .data    (data),
    .salida  (salida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // After reset the output pipeline holds zeros.
  task automatic reset_pipe();
    exp_t z;
    sb_q.delete();
    z.val = '0; z.known = 1'b1; z.mode = 0; z.name = "pipe_zero";
    for (int i = 0; i < LAT - 1; i++) sb_q.push_back(z);
  endtask

  // mode 0: exact compare when the model knows the word; mode 1: must differ from 32'hFFFFFFFF
  task automatic cycle(input bit w, input logic [9:0] a, input logic [31:0] d,
                       input string name, input int mode);
    exp_t e, got;
    @(negedge clock);
    wren = w; address = a; data = d;
    e.name = name; e.mode = mode;
    if (w) begin
      e.val = d; e.known = 1'b1;
      model_mem[a] = d; model_known[a] = 1'b1;
    end else begin
      e.val = model_mem[a]; e.known = model_known[a];
    end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    if (got.mode == 1) begin
      n_vec++;
      if (salida === 32'hFFFFFFFF) begin
        n_err++;
        $display("FAIL %s: salida=%h must differ from ffffffff", got.name, salida);
      end else $display("ok   %s: salida=%h (not ffffffff)", got.name, salida);
    end else if (got.known) begin
      n_vec++;
      if (salida !== got.val) begin
        n_err++;
        $display("FAIL %s: salida=%h expected %h", got.name, salida, got.val);
      end else $display("ok   %s: salida=%h", got.name, salida);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wren = 1'b1; data = 32'hFFFFFFFF; address = 10'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      n_vec++;
      if (salida !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold_%0d: salida=%h expected 00000000", i, salida);
      end else $display("ok   reset_hold_%0d: salida=%h", i, salida);
    end
    @(negedge clock);
    wren = 1'b0;
    reset_n = 1'b1;
    reset_pipe();
    #1;
    n_vec++;
    if (salida !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release: salida=%h expected 00000000", salida);
    end else $display("ok   reset_release: salida=%h", salida);
    cycle(1'b0, 10'd5, 32'h0, "reset_addr5_not_written", 1);
    for (int i = 0; i < LAT - 1; i++) cycle(1'b0, 10'd5, 32'h0, "reset_drain", 1);
  endtask

  task automatic test_write_read();
    cycle(1'b0, 10'd1,  32'd43, "wr1_pre", 0);
    cycle(1'b1, 10'd1,  32'd43, "wr1_write", 0);
    cycle(1'b0, 10'd1,  32'd43, "wr1_read", 0);
    cycle(1'b0, 10'd32, 32'd61, "wr32_pre", 0);
    cycle(1'b1, 10'd32, 32'd61, "wr32_write", 0);
    cycle(1'b0, 10'd32, 32'd61, "wr32_read", 0);
    cycle(1'b0, 10'd1,  32'd0,  "alias_read1", 0);
    cycle(1'b0, 10'd32, 32'd0,  "alias_read32", 0);
  endtask

  task automatic test_boundaries();
    cycle(1'b1, 10'd0,    32'h80000000, "bnd_write0", 0);
    cycle(1'b1, 10'd1023, 32'h7FFFFFFF, "bnd_write1023", 0);
    cycle(1'b0, 10'd0,    32'h0,        "bnd_read0", 0);
    cycle(1'b0, 10'd1023, 32'h0,        "bnd_read1023", 0);
    cycle(1'b0, 10'd1,    32'h0,        "bnd_read1", 0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 10'd7, 32'd10, "b2b_write10", 0);
    cycle(1'b1, 10'd7, 32'd20, "b2b_write20", 0);
    cycle(1'b0, 10'd7, 32'd0,  "b2b_hold20", 0);
    cycle(1'b0, 10'd7, 32'd0,  "b2b_hold20_again", 0);
    for (int i = 0; i < 6; i++) begin
      logic [9:0]  a;
      logic [31:0] d;
      a = 10'($urandom_range(100, 200));
      d = $urandom;
      cycle(1'b1, a, d, $sformatf("rnd_write_%0d", i), 0);
      cycle(1'b0, a, 32'h0, $sformatf("rnd_read_%0d", i), 0);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (salida !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_clear: salida=%h expected 00000000", salida);
    end else $display("ok   async_reset_clear: salida=%h", salida);
    #1;
    reset_n = 1'b1;
    reset_pipe();
    cycle(1'b0, 10'd32, 32'h0, "async_read32", 0);
    cycle(1'b0, 10'd7,  32'h0, "async_read7", 0);
    for (int i = 0; i < LAT - 1; i++) cycle(1'b0, 10'd0, 32'h0, "drain", 0);
  endtask

  initial begin
    reset_n = 1'b0; wren = 1'b0; address = '0; data = '0;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = '0;
      model_known[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_boundaries();
    test_back_to_back();
    cycle(1'b0, 10'd1, 32'h0, "keep_running", 0);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
